alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal range 4..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; accepted only on an edge where ready=1.
REQ-005 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-006 SHALL have port datoA  input  WIDTH  first operand, captured on accept.
REQ-007 SHALL have port datoB  input  WIDTH  second operand, captured on accept.
REQ-008 SHALL have port opCode  input  4  ARM data-processing opcode, captured on accept.
REQ-009 SHALL have port cin  input  1  carry-in for ADC/SBC/RSC and SUB-family borrow, captured on accept.
REQ-010 SHALL have port mul  input  1  multiply request, captured on accept; opCode ignored when mul=1.
REQ-011 SHALL have port salida  output  WIDTH  registered result.
REQ-012 SHALL have ports cout, zero, negative, overflow  output  1 each  registered C, Z, N, V flags.
REQ-013 SHALL have port done  output  1  one-cycle pulse when salida/flags are updated.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, MUL; ready=1 only in IDLE.
REQ-015 IDLE with start=1: capture operands, opCode, cin, mul; go to MUL if mul=1 (and ALU_MUL_EN defined), else EXEC.
REQ-016 EXEC SHALL compute in one cycle, register result and flags, pulse done, and return to IDLE; done is high exactly 1 cycle after accept.
REQ-017 Opcodes: 0000 AND, 0001 EOR, 0010 SUB A-B, 0011 RSB B-A, 0100 ADD, 0101 ADC A+B+cin, 0110 SBC A-B-!cin, 0111 RSC B-A-!cin, 1000 TST, 1001 TEQ, 1010 CMP, 1011 CMN, 1100 ORR, 1101 MOV B, 1110 BIC A&~B, 1111 MVN ~B.
REQ-018 SUB/RSB/CMP SHALL compute with carry-in 1 (cin ignored); C = NOT borrow.
REQ-019 Arithmetic ops SHALL update N (MSB), Z (result==0), C (carry out of bit WIDTH-1), V (signed overflow).
REQ-020 Logical ops (AND, EOR, ORR, MOV, BIC, MVN, TST, TEQ) SHALL update N, Z, and set C=captured cin; V unchanged.
REQ-021 TST/TEQ/CMP/CMN SHALL update flags only; salida unchanged; done still pulses.
REQ-022 MUL SHALL compute datoA*datoB by shift-add, one bit per cycle over WIDTH cycles; done high exactly WIDTH cycles after accept.
REQ-023 MUL result SHALL be low WIDTH bits of product; N, Z updated; C, V unchanged.
REQ-024 start while ready=0 SHALL be ignored, no queueing; operand changes while busy SHALL not affect the result.
REQ-025 salida and flags SHALL hold their last values until the next completion.
REQ-026 start asserted in the done cycle SHALL be accepted, since the FSM is in IDLE then (back-to-back ops, one per 2 cycles for EXEC).

Reset
REQ-027 rst_n low SHALL immediately force IDLE, ready=1, done=0, salida=0, cout=zero=negative=overflow=0, clear multiplier state.
REQ-028 Reset during EXEC or MUL SHALL abort the operation with no done pulse; first accept is possible on the first edge after rst_n rises.

Configuration
REQ-029 Macro ALU_MUL_EN SHALL, when defined, include the MUL state and shift-add datapath.
REQ-030 Without ALU_MUL_EN, mul SHALL be ignored, all requests go to EXEC, and no multiplier logic is synthesised.

Verification
REQ-031 ADD datoA=10, datoB=10, cin=0 -> done 1 cycle after accept, salida=20, Z=0, C=0, N=0, V=0.
REQ-032 SUB 10-10 -> salida=0, Z=1, C=1; CMP 0 vs 10 -> salida unchanged, N=1, C=0.
REQ-033 ADD 0xFFFFFFFF+1 -> salida=0, Z=1, C=1; ADD 0x7FFFFFFF+1 -> salida=0x80000000, N=1, V=1.
REQ-034 AND 11&11 -> 11; AND 6&4 -> 4; AND 0&0 -> 0, Z=1, C=cin.
REQ-035 With ALU_MUL_EN: mul=1, 6*4 -> done exactly 32 cycles later, salida=24; start pulsed mid-multiply is ignored.
REQ-036 rst_n low at cycle 10 of a multiply -> all outputs 0, ready=1, no done pulse; a subsequent ADD 40+52 returns 92.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle ARM-style ALU: one-cycle data-processing ops plus an optional shift-add multiplier.
// Define ALU_MUL_EN to include the MUL state and multiplier datapath.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] datoA,
  input  logic [WIDTH-1:0] datoB,
  input  logic [3:0]       opCode,
  input  logic             cin,
  input  logic             mul,
  output logic [WIDTH-1:0] salida,
  output logic             cout,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StExec, StMul} state_e;

  localparam logic [3:0] OpAnd = 4'h0, OpEor = 4'h1, OpSub = 4'h2, OpRsb = 4'h3;
  localparam logic [3:0] OpAdd = 4'h4, OpAdc = 4'h5, OpSbc = 4'h6, OpRsc = 4'h7;
  localparam logic [3:0] OpTst = 4'h8, OpTeq = 4'h9, OpCmp = 4'hA, OpCmn = 4'hB;
  localparam logic [3:0] OpOrr = 4'hC, OpMov = 4'hD, OpBic = 4'hE, OpMvn = 4'hF;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] salida_q, salida_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             v_q, v_d;
  logic             done_q, done_d;

  logic accept;

`ifdef ALU_MUL_EN
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_sum;
  logic             mul_last;
`else
  logic unused_mul;
  assign unused_mul = mul;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
`ifdef ALU_MUL_EN
          state_d = mul ? StMul : StExec;
`else
          state_d = StExec;
`endif
        end
      end
      StExec: state_d = StIdle;
`ifdef ALU_MUL_EN
      StMul: begin
        if (mul_last) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready  = (state_q == StIdle);
    accept = ready & start;
  end

  // ---------------------------------------------------------------------------
  // One-cycle ALU
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] add_x, add_y, logic_res, alu_res;
  logic             add_ci, is_arith, flags_only, alu_c, alu_v;
  logic [WIDTH:0]   add_sum;

  always_comb begin
    add_x  = a_q;
    add_y  = b_q;
    add_ci = 1'b0;
    // Subtraction is x + ~y + carry, so C comes out as NOT borrow.
    unique case (op_q)
      OpSub, OpCmp: begin add_y = ~b_q; add_ci = 1'b1;  end
      OpRsb:        begin add_x = b_q; add_y = ~a_q; add_ci = 1'b1; end
      OpAdc:        add_ci = cin_q;
      OpSbc:        begin add_y = ~b_q; add_ci = cin_q; end
      OpRsc:        begin add_x = b_q; add_y = ~a_q; add_ci = cin_q; end
      default:      ;
    endcase
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
    alu_c   = add_sum[WIDTH];
    alu_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);

    unique case (op_q)
      OpAnd, OpTst: logic_res = a_q & b_q;
      OpEor, OpTeq: logic_res = a_q ^ b_q;
      OpOrr:        logic_res = a_q | b_q;
      OpMov:        logic_res = b_q;
      OpBic:        logic_res = a_q & ~b_q;
      OpMvn:        logic_res = ~b_q;
      default:      logic_res = '0;
    endcase

    is_arith   = (op_q inside {OpSub, OpRsb, OpAdd, OpAdc, OpSbc, OpRsc, OpCmp, OpCmn});
    flags_only = (op_q inside {OpTst, OpTeq, OpCmp, OpCmn});
    alu_res    = is_arith ? add_sum[WIDTH-1:0] : logic_res;
  end

`ifdef ALU_MUL_EN
  // a_q shifts left as the multiplicand, b_q shifts right as the multiplier.
  always_comb begin
    mul_sum  = acc_q + (b_q[0] ? a_q : '0);
    mul_last = (cnt_q == LastCnt);
  end
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cin_d    = cin_q;
    salida_d = salida_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    done_d   = 1'b0;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif

    if (accept) begin
      a_d   = datoA;
      b_d   = datoB;
      op_d  = opCode;
      cin_d = cin;
`ifdef ALU_MUL_EN
      acc_d = '0;
      cnt_d = '0;
`endif
    end

    if (state_q == StExec) begin
      if (!flags_only) salida_d = alu_res;
      n_d    = alu_res[WIDTH-1];
      z_d    = (alu_res == '0);
      c_d    = is_arith ? alu_c : cin_q;
      if (is_arith) v_d = alu_v;
      done_d = 1'b1;
    end

`ifdef ALU_MUL_EN
    if (state_q == StMul) begin
      acc_d = mul_sum;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (mul_last) begin
        salida_d = mul_sum;
        n_d      = mul_sum[WIDTH-1];
        z_d      = (mul_sum == '0);
        done_d   = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      salida_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      salida_q <= salida_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      done_q   <= done_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign salida   = salida_q;
  assign cout     = c_q;
  assign zero     = z_q;
  assign negative = n_q;
  assign overflow = v_q;
  assign done     = done_q;

endmodule
